// File: rtl/music_box_melody_player.sv
// Plays a fixed 16-entry melody from ROM as a registered square wave, looping forever.
// Each note is followed by a silent gap; tone phase restarts at every note boundary.
module music_box_melody_player #(
    parameter int unsigned CLK_HZ      = 12_000_000,
    parameter int unsigned UNIT_CYCLES = 1_500_000,
    parameter int unsigned GAP_CYCLES  = UNIT_CYCLES / 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic speaker
);

    // Lowest base pitch is 262 Hz, so its half-period bounds the tone counter.
    localparam int unsigned TW = $clog2(CLK_HZ / 524 + 1);
    localparam int unsigned DW = $clog2(UNIT_CYCLES * 8 + 1);

    function automatic int unsigned base_hz(input int unsigned note);
        case (note)
            1:       return 262;
            2:       return 277;
            3:       return 294;
            4:       return 311;
            5:       return 330;
            6:       return 349;
            7:       return 370;
            8:       return 392;
            9:       return 415;
            10:      return 440;
            11:      return 466;
            12:      return 494;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] rom_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h51;
            4'd1:    return 8'h51;
            4'd2:    return 8'h61;
            4'd3:    return 8'h81;
            4'd4:    return 8'h81;
            4'd5:    return 8'h61;
            4'd6:    return 8'h51;
            4'd7:    return 8'h31;
            4'd8:    return 8'h11;
            4'd9:    return 8'h11;
            4'd10:   return 8'h31;
            4'd11:   return 8'h51;
            4'd12:   return 8'h52;
            4'd13:   return 8'h30;
            4'd14:   return 8'h32;
            default: return 8'h02;
        endcase
    endfunction

    // Half-period table indexed by {note, octave}, fully resolved at elaboration.
    logic [TW-1:0] w_half_tab [64];
    for (genvar gn = 0; gn < 16; gn++) begin : g_note
        for (genvar go = 0; go < 4; go++) begin : g_oct
            localparam int unsigned Hz   = base_hz(gn);
            localparam int unsigned Div  = (Hz == 0) ? 1 : 2 * Hz;
            localparam int unsigned Half = (Hz == 0) ? 0 : (CLK_HZ / Div) >> go;
            assign w_half_tab[gn*4+go] = TW'(Half);
        end
    end

    logic [3:0]    r_idx;
    logic [DW-1:0] r_dur;
    logic [TW-1:0] r_tone;
    logic          r_spk;

    logic [7:0]    w_entry;
    logic [3:0]    w_note;
    logic [1:0]    w_oct;
    logic [1:0]    w_len;
    logic [TW-1:0] w_half;
    logic [DW-1:0] w_dur_last;
    logic [DW-1:0] w_gap_from;
    logic          w_rest;
    logic          w_start;
    logic          w_last;
    logic          w_gap;
    logic [3:0]    w_idx_d;
    logic [DW-1:0] w_dur_d;
    logic [TW-1:0] w_tone_d;
    logic          w_spk_d;

    assign w_entry = rom_entry(r_idx);
    assign w_note  = w_entry[7:4];
    assign w_oct   = w_entry[3:2];
    assign w_len   = w_entry[1:0];
    assign w_half  = w_half_tab[{w_note, w_oct}];
    assign w_rest  = (w_note == 4'd0) || (w_note > 4'd12);

    always_comb begin
        w_dur_last = DW'(UNIT_CYCLES - 1);
        w_gap_from = DW'(UNIT_CYCLES - GAP_CYCLES);
        case (w_len)
            2'd1: begin
                w_dur_last = DW'(2 * UNIT_CYCLES - 1);
                w_gap_from = DW'(2 * UNIT_CYCLES - GAP_CYCLES);
            end
            2'd2: begin
                w_dur_last = DW'(4 * UNIT_CYCLES - 1);
                w_gap_from = DW'(4 * UNIT_CYCLES - GAP_CYCLES);
            end
            2'd3: begin
                w_dur_last = DW'(8 * UNIT_CYCLES - 1);
                w_gap_from = DW'(8 * UNIT_CYCLES - GAP_CYCLES);
            end
            default: ;
        endcase
    end

    // r_dur holds the position of the upcoming edge within the note; 0 marks a note start.
    assign w_start = (r_dur == '0);
    assign w_last  = (r_dur == w_dur_last);
    assign w_gap   = (r_dur >= w_gap_from);

    always_comb begin
        w_idx_d  = r_idx;
        w_dur_d  = r_dur + 1'b1;
        w_tone_d = r_tone + 1'b1;
        w_spk_d  = r_spk;
        if (w_last) begin
            w_dur_d = '0;
            w_idx_d = r_idx + 1'b1;
        end
        if (w_start || w_gap || w_rest) begin
            w_tone_d = '0;
            w_spk_d  = 1'b0;
        end else if (r_tone == w_half - 1'b1) begin
            w_tone_d = '0;
            w_spk_d  = ~r_spk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_dur  <= '0;
            r_tone <= '0;
            r_spk  <= 1'b0;
        end else begin
            r_idx  <= w_idx_d;
            r_dur  <= w_dur_d;
            r_tone <= w_tone_d;
            r_spk  <= w_spk_d;
        end
    end

    assign speaker = r_spk;

endmodule

// File: tb/tb_music_box_melody_player.sv
// Directed bench: every cycle compares speaker against a schedule-level model of the tune,
// plus literal expectations at hand-computed cycles and an asynchronous mid-note reset.
module tb_music_box_melody_player;

    localparam int unsigned CLK_HZ      = 100_000;
    localparam int unsigned UNIT_CYCLES = 400;
    localparam int unsigned GAP_CYCLES  = 50;

    logic clk;
    logic rst_n;
    logic speaker;

    music_box_melody_player #(
        .CLK_HZ     (CLK_HZ),
        .UNIT_CYCLES(UNIT_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .speaker(speaker)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int mel_note [16] = '{5, 5, 6, 8, 8, 6, 5, 3, 1, 1, 3, 5, 5, 3, 3, 0};
    int mel_len  [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 0, 2, 2};
    int base_hz  [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};

    int lit_cyc [22] = '{150, 151, 301, 302, 603, 604, 750, 800, 951, 1000, 1742,
                         1743, 1886, 2029, 6590, 6780, 6970, 7149, 7150, 13200, 14950, 14951};
    logic lit_val [22] = '{0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0,
                           1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1};

    int vectors;
    int miscompares;
    int cyc;

    task automatic check(input string name, input int at, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: speaker=%0b expected %0b", name, at, got, exp);
        end
    endtask

    // Expected speaker after edge c (counted from release), from note schedule arithmetic.
    function automatic logic model_spk(input int c);
        int loop_len;
        int t;
        int s;
        int d;
        int p;
        int h;
        loop_len = 0;
        for (int k = 0; k < 16; k++) loop_len += UNIT_CYCLES << mel_len[k];
        t = c % loop_len;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            d = UNIT_CYCLES << mel_len[k];
            if (t < s + d) begin
                p = t - s;
                if (mel_note[k] == 0 || p >= d - GAP_CYCLES) return 1'b0;
                h = CLK_HZ / (2 * base_hz[mel_note[k] - 1]);
                return ((p / h) % 2) == 1;
            end
            s += d;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            cyc++;
            check("model", cyc, speaker, model_spk(cyc));
            for (int i = 0; i < 22; i++) begin
                if (cyc == lit_cyc[i]) check("literal", cyc, speaker, lit_val[i]);
            end
        end else begin
            cyc = -1;
            check("reset", cyc, speaker, 1'b0);
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = -1;
        rst_n       = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 1100 && cyc < 1000; i++) @(negedge clk);
        if (cyc != 1000) begin
            vectors++;
            miscompares++;
            $display("FAIL reach_cycle_1000: cycle=%0d expected 1000", cyc);
        end
        // Mid-note reset: E4 is high at cycle 1000, so the drop is visible without an edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", cyc, speaker, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        repeat (15300) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
